sram_pixel_fetcher: RTL and testbench

Frame-read sequencer sitting directly upstream of the top-level display unpacker. Walks the stored image in raster order, issues two 16-bit async-SRAM reads per pixel (word 1 at even address, word 2 at odd address), and delivers each pixel as a `{word_1, word_2}` pair through a small FIFO with valid/ready handshake. Those are the `i_sram_data_1`/`i_sram_data_2` values the unpacker consumes. One pixel is issued per 2 cycles when unstalled.

---
 rtl/fetch_pkg.sv | 32 +++
 rtl/sync_fifo.sv | 58 +++++
 rtl/sram_pixel_fetcher.sv | 157 +++++++++++++++
 tb/tb_sram_pixel_fetcher.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the SRAM pixel fetcher and its output FIFO.
package fetch_pkg;

  localparam int unsigned SRAM_ADDR_W = 20;
  localparam int unsigned SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    W1,
    W2,
    WAIT
  } fetch_state_e;

  typedef struct packed {
    logic                   eol;
    logic                   last;
    logic [SRAM_DATA_W-1:0] word_1;
    logic [SRAM_DATA_W-1:0] word_2;
  } pix_entry_t;

  // Word address of one half of pixel p; wraps modulo 2^SRAM_ADDR_W.
  function automatic logic [SRAM_ADDR_W-1:0] pix_addr(
    input logic [SRAM_ADDR_W-1:0] base,
    input logic [31:0]            p,
    input logic                   second
  );
    logic [SRAM_ADDR_W-1:0] offs;
    offs = SRAM_ADDR_W'(p << 1);
    return base + offs + SRAM_ADDR_W'(second);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, power-of-two depth; simultaneous push and pop is legal at any fill level.
module sync_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so push into full is accepted then.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_pixel_fetcher.sv
// Raster-order frame reader: two async-SRAM word reads per pixel, delivered through a small FIFO.
module sram_pixel_fetcher
  import fetch_pkg::*;
#(
  parameter int unsigned            IMG_W      = 640,
  parameter int unsigned            IMG_H      = 480,
  parameter logic [SRAM_ADDR_W-1:0] BASE_ADDR  = 20'h0,
  parameter int unsigned            FIFO_DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  output logic                   o_busy,
  output logic [SRAM_ADDR_W-1:0] o_sram_addr,
  output logic                   o_sram_ce_n,
  output logic                   o_sram_oe_n,
  output logic                   o_sram_we_n,
  output logic                   o_sram_ub_n,
  output logic                   o_sram_lb_n,
  input  logic [SRAM_DATA_W-1:0] i_sram_dq,
  output logic                   o_pix_valid,
  input  logic                   i_pix_ready,
  output logic [SRAM_DATA_W-1:0] o_pix_data_1,
  output logic [SRAM_DATA_W-1:0] o_pix_data_2,
  output logic                   o_pix_eol,
  output logic                   o_pix_last
);

  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned P_W   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned X_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e           state;
  fetch_state_e           state_next;
  logic [P_W-1:0]         p_q;
  logic [X_W-1:0]         x_q;
  logic [SRAM_DATA_W-1:0] word1_q;
  logic                   is_last;
  logic                   is_eol;

  logic                   fifo_push;
  logic                   fifo_pop;
  pix_entry_t             fifo_din;
  pix_entry_t             fifo_dout;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_empty;
  logic                   fifo_full;

  assign is_last = (p_q == P_W'(NPIX - 1));
  assign is_eol  = (x_q == X_W'(IMG_W - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (i_start) state_next = W1;
      W1:   state_next = W2;
      W2: begin
        // Pre-push count decides: leaving room for one more push keeps W2 from ever seeing a full FIFO.
        if (is_last) begin
          state_next = IDLE;
        end else if (fifo_count <= CNT_W'(FIFO_DEPTH - 2)) begin
          state_next = W1;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: if (!fifo_full) state_next = W1;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_sram_ce_n = 1'b1;
    o_sram_oe_n = 1'b1;
    o_sram_addr = '0;
    fifo_push   = 1'b0;
    unique case (state)
      W1: begin
        o_sram_ce_n = 1'b0;
        o_sram_oe_n = 1'b0;
        o_sram_addr = pix_addr(BASE_ADDR, 32'(p_q), 1'b0);
      end
      W2: begin
        o_sram_ce_n = 1'b0;
        o_sram_oe_n = 1'b0;
        o_sram_addr = pix_addr(BASE_ADDR, 32'(p_q), 1'b1);
        fifo_push   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p_q     <= '0;
      x_q     <= '0;
      word1_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_start) begin
            p_q <= '0;
            x_q <= '0;
          end
        end
        W1: word1_q <= i_sram_dq;
        W2: begin
          if (!is_last) begin
            p_q <= p_q + P_W'(1);
            x_q <= is_eol ? '0 : x_q + X_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign fifo_din = '{eol: is_eol, last: is_last, word_1: word1_q, word_2: i_sram_dq};
  assign fifo_pop = o_pix_valid && i_pix_ready;

  sync_fifo #(
    .WIDTH($bits(pix_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Head fields are forced to zero when empty so stale storage never shows on the outputs.
  assign o_pix_valid  = !fifo_empty;
  assign o_pix_data_1 = fifo_empty ? '0 : fifo_dout.word_1;
  assign o_pix_data_2 = fifo_empty ? '0 : fifo_dout.word_2;
  assign o_pix_eol    = !fifo_empty && fifo_dout.eol;
  assign o_pix_last   = !fifo_empty && fifo_dout.last;

  assign o_busy      = (state != IDLE) || !fifo_empty;
  assign o_sram_we_n = 1'b1;
  assign o_sram_ub_n = 1'b0;
  assign o_sram_lb_n = 1'b0;

endmodule

// File: tb/tb_sram_pixel_fetcher.sv
// Randomized bench for sram_pixel_fetcher on a 4x2 frame against an arithmetic pixel model.
module tb_sram_pixel_fetcher;

  localparam int unsigned W    = 4;
  localparam int unsigned H    = 2;
  localparam int unsigned N    = W * H;
  localparam logic [19:0] BASE = 20'h100;
  localparam logic [60:0] RST_OUT = {1'b0, 20'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00};

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic        o_busy;
  logic [19:0] o_sram_addr;
  logic        o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_ub_n, o_sram_lb_n;
  logic [15:0] i_sram_dq;
  logic        o_pix_valid;
  logic        i_pix_ready;
  logic [15:0] o_pix_data_1, o_pix_data_2;
  logic        o_pix_eol, o_pix_last;

  logic [15:0] key;
  logic [33:0] exp_q[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned peak  = 0;
  logic        we_bad = 1'b0;

  always #5 clk = ~clk;

  // SRAM model: data is the low address bits scrambled by a per-frame key.
  assign i_sram_dq = o_sram_addr[15:0] ^ key;

  sram_pixel_fetcher #(
    .IMG_W     (W),
    .IMG_H     (H),
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(4)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .o_busy      (o_busy),
    .o_sram_addr (o_sram_addr),
    .o_sram_ce_n (o_sram_ce_n),
    .o_sram_oe_n (o_sram_oe_n),
    .o_sram_we_n (o_sram_we_n),
    .o_sram_ub_n (o_sram_ub_n),
    .o_sram_lb_n (o_sram_lb_n),
    .i_sram_dq   (i_sram_dq),
    .o_pix_valid (o_pix_valid),
    .i_pix_ready (i_pix_ready),
    .o_pix_data_1(o_pix_data_1),
    .o_pix_data_2(o_pix_data_2),
    .o_pix_eol   (o_pix_eol),
    .o_pix_last  (o_pix_last)
  );

  always @(negedge clk) begin
    if (int'(dut.fifo_count) > peak) peak = int'(dut.fifo_count);
    if (o_sram_we_n !== 1'b1) we_bad = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [60:0] out_vec();
    return {o_busy, o_sram_addr, o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_ub_n,
            o_sram_lb_n, o_pix_valid, o_pix_data_1, o_pix_data_2, o_pix_eol, o_pix_last};
  endfunction

  task automatic build_expected();
    logic [19:0] a1;
    logic [19:0] a2;
    logic [15:0] w1;
    logic [15:0] w2;
    key = 16'($urandom);
    exp_q.delete();
    for (int p = 0; p < int'(N); p++) begin
      a1 = BASE + 20'(2 * p);
      a2 = a1 + 20'd1;
      w1 = a1[15:0] ^ key;
      w2 = a2[15:0] ^ key;
      exp_q.push_back({(p % int'(W)) == int'(W) - 1, p == int'(N) - 1, w1, w2});
    end
  endtask

  // mode 0: ready high, 1: ready low then raised, 2: ready toggling, 3: random ready, 4: reset mid-frame
  task automatic run_frame(input int mode, input bit start_mid);
    int  popped = 0;
    bit  done = 0;
    build_expected();
    @(negedge clk);
    i_start = 1'b1;
    for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
      @(negedge clk);
      i_start = start_mid && (cyc == 5);
      case (mode)
        1:       i_pix_ready = (cyc >= 30);
        2:       i_pix_ready = (cyc % 2 == 1);
        3:       i_pix_ready = 1'($urandom_range(0, 1));
        default: i_pix_ready = 1'b1;
      endcase
      if (mode == 0) begin
        if (cyc <= int'(2 * N) + 1) begin
          check("addr", o_sram_addr, (cyc <= int'(2 * N)) ? BASE + 20'(cyc - 1) : 20'h0);
          check("ce_oe", {o_sram_ce_n, o_sram_oe_n}, (cyc <= int'(2 * N)) ? 2'b00 : 2'b11);
        end
        if (cyc == 2) check("valid_c2", o_pix_valid, 1'b0);
        if (popped < int'(N)) check("busy_run", o_busy, 1'b1);
      end
      if (mode == 1 && cyc == 29) begin
        check("bp_depth", dut.fifo_count, 4);
        check("bp_ce_oe", {o_sram_ce_n, o_sram_oe_n}, 2'b11);
        check("bp_valid", o_pix_valid, 1'b1);
      end
      if (mode == 4 && cyc == 8) begin
        check("pre_rst_addr", o_sram_addr, BASE + 20'd7);
        #2 i_rst_n = 1'b0;
        #1 check("rst_async", out_vec(), RST_OUT);
        @(negedge clk);
        check("rst_held", out_vec(), RST_OUT);
        i_rst_n = 1'b1;
        done = 1;
      end else if (o_pix_valid && i_pix_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_pix", {o_pix_eol, o_pix_last, o_pix_data_1, o_pix_data_2}, 34'h0);
        end else begin
          check("pix", {o_pix_eol, o_pix_last, o_pix_data_1, o_pix_data_2}, exp_q.pop_front());
          if (mode == 0) check("pop_cyc", cyc, 3 + 2 * popped);
          popped++;
        end
      end else if (popped == int'(N)) begin
        check("busy_end", o_busy, 1'b0);
        done = 1;
      end
    end
    check("frame_done", done, 1'b1);
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_start     = 1'b0;
    i_pix_ready = 1'b0;
    key         = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      i_start     = 1'($urandom_range(0, 1));
      i_pix_ready = 1'($urandom_range(0, 1));
      key         = 16'($urandom);
      #1 check("rst_hold", out_vec(), RST_OUT);
    end
    @(negedge clk);
    i_start = 1'b0;
    i_rst_n = 1'b1;
    #1 check("post_release", out_vec(), RST_OUT);

    run_frame(0, 1'b0);
    run_frame(1, 1'b0);
    run_frame(2, 1'b0);
    run_frame(0, 1'b1);
    run_frame(0, 1'b0);
    run_frame(4, 1'b0);
    run_frame(0, 1'b0);
    for (int i = 0; i < 3; i++) run_frame(3, 1'b0);

    check("fifo_overflow", peak > 4, 1'b0);
    check("we_n_const", we_bad, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
